// File: rtl/param_counter.sv
// -----------------------------------------------------------------------------
// param_counter
//   Parametrised up/down counter with parallel load, enable, configurable
//   modulus and step, wrap or saturate at the range limits, and a registered
//   one-cycle overflow pulse for cascading. Single clock domain.
//
// Parameters
//   WIDTH    counter width in bits (>= 2)
//   MAX_VAL  top of the count range, range is 0..MAX_VAL inclusive (>= 1)
//   RST_VAL  count value after reset (<= MAX_VAL)
//   SATURATE 0: wrap modulo MAX_VAL+1, 1: clamp at 0 / MAX_VAL
//   PRESCALE enabled cycles per count step (only with PCNT_PRESCALE_EN)
//
// Configuration macro
//   PCNT_PRESCALE_EN  when defined, an internal prescaler counts enabled
//                     cycles 0..PRESCALE-1 and the counter steps only on the
//                     last one. When undefined every enabled cycle steps and
//                     no prescaler flops exist.
//
// Ports
//   i_clk      in   1      clock, rising edge
//   i_rst      in   1      synchronous active-high reset
//   i_en       in   1      count enable
//   i_up       in   1      1 = add step, 0 = subtract step
//   i_step     in   WIDTH  step magnitude (0 = hold)
//   i_load     in   1      parallel load strobe
//   i_load_val in   WIDTH  load value (clamped to MAX_VAL)
//   o_p        out  WIDTH  current count (register)
//   o_ovf      out  1      pulse: previous step crossed or clipped at a limit
//   o_zero     out  1      o_p == 0
// -----------------------------------------------------------------------------
module param_counter #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}},
  parameter bit               SATURATE = 1'b0,
  parameter int unsigned      PRESCALE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up,
  input  logic [WIDTH-1:0] i_step,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_p,
  output logic             o_ovf,
  output logic             o_zero
);

  // Modulus of the wrapping range; MAX_VAL+1 always fits in WIDTH+1 bits.
  localparam logic [WIDTH:0] MOD_VAL = {1'b0, MAX_VAL} + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] p_r;
  logic             ovf_r;
  logic             tick_s;

  logic [WIDTH-1:0] step_eff_s;
  logic [WIDTH-1:0] load_clamp_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   wrap_up_s;
  logic [WIDTH:0]   wrap_dn_s;
  logic [WIDTH-1:0] step_p_s;
  logic             step_ovf_s;

`ifdef PCNT_PRESCALE_EN
  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_r;

  assign tick_s = (ps_r == PS_LAST);

  // Prescaler: advances on enabled cycles, wraps on tick, cleared by reset/load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ps_r <= {PS_W{1'b0}};
    end else if (i_load) begin
      ps_r <= {PS_W{1'b0}};
    end else if (i_en) begin
      if (tick_s) begin
        ps_r <= {PS_W{1'b0}};
      end else begin
        ps_r <= ps_r + PS_W'(1);
      end
    end else begin
      ps_r <= ps_r;
    end
  end
`else
  // PRESCALE has no effect without the prescaler; keep it referenced.
  logic unused_prescale_s;
  assign unused_prescale_s = (PRESCALE == 32'd0);
  assign tick_s            = 1'b1;
`endif

  assign o_p    = p_r;
  assign o_ovf  = ovf_r;
  assign o_zero = (p_r == {WIDTH{1'b0}});

  // Next-count arithmetic, done one bit wider so overflow is a plain compare.
  always_comb begin
    step_eff_s   = (i_step > MAX_VAL) ? MAX_VAL : i_step;
    load_clamp_s = (i_load_val > MAX_VAL) ? MAX_VAL : i_load_val;
    sum_s        = {1'b0, p_r} + {1'b0, step_eff_s};
    wrap_up_s    = sum_s - MOD_VAL;
    // p + (MAX_VAL+1) - s: non-negative and below the modulus on underflow.
    wrap_dn_s    = {1'b0, p_r} + MOD_VAL - {1'b0, step_eff_s};
    step_p_s     = p_r;
    step_ovf_s   = 1'b0;
    if (i_up) begin
      if (sum_s > {1'b0, MAX_VAL}) begin
        step_ovf_s = 1'b1;
        step_p_s   = SATURATE ? MAX_VAL : wrap_up_s[WIDTH-1:0];
      end else begin
        step_ovf_s = 1'b0;
        step_p_s   = sum_s[WIDTH-1:0];
      end
    end else begin
      if (step_eff_s > p_r) begin
        step_ovf_s = 1'b1;
        step_p_s   = SATURATE ? {WIDTH{1'b0}} : wrap_dn_s[WIDTH-1:0];
      end else begin
        step_ovf_s = 1'b0;
        step_p_s   = p_r - step_eff_s;
      end
    end
  end

  // Count register and overflow pulse: reset > load > enabled tick > hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_r   <= RST_VAL;
      ovf_r <= 1'b0;
    end else if (i_load) begin
      p_r   <= load_clamp_s;
      ovf_r <= 1'b0;
    end else if (i_en && tick_s) begin
      p_r   <= step_p_s;
      ovf_r <= step_ovf_s;
    end else begin
      p_r   <= p_r;
      ovf_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// -----------------------------------------------------------------------------
// tb_param_counter
//   Directed self-checking bench for param_counter. Four instances share one
//   stimulus bus: a 16-bit default counter, a mod-10 wrapping counter, a
//   mod-10 saturating counter and an 8-bit 0..99 counter with RST_VAL=7.
//   Each scenario checks only the instance it targets. With
//   PCNT_PRESCALE_EN defined the prescaler scenario runs instead of the
//   per-step scenarios.
// -----------------------------------------------------------------------------
module tb_param_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic [15:0] step;
  logic        load;
  logic [15:0] lv;

  logic [15:0] p16;
  logic        ovf16, z16;
  logic [3:0]  p9w;
  logic        ovf9w, z9w;
  logic [3:0]  p9s;
  logic        ovf9s, z9s;
  logic [7:0]  p99;
  logic        ovf99, z99;

  int n_checks = 0;
  int n_errors = 0;

  param_counter u_c16 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_step(step),
    .i_load(load), .i_load_val(lv), .o_p(p16), .o_ovf(ovf16), .o_zero(z16)
  );

  param_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_mod9 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_step(step[3:0]),
    .i_load(load), .i_load_val(lv[3:0]), .o_p(p9w), .o_ovf(ovf9w), .o_zero(z9w)
  );

  param_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat9 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_step(step[3:0]),
    .i_load(load), .i_load_val(lv[3:0]), .o_p(p9s), .o_ovf(ovf9s), .o_zero(z9s)
  );

  param_counter #(.WIDTH(8), .MAX_VAL(8'd99), .RST_VAL(8'd7)) u_c99 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_step(step[7:0]),
    .i_load(load), .i_load_val(lv[7:0]), .o_p(p99), .o_ovf(ovf99), .o_zero(z99)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] val);
    en   = 1'b0;
    load = 1'b1;
    lv   = val;
    clk_step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; step = 16'd1; load = 1'b0; lv = 16'd0;

    // Reset held for two clocks
    clk_step();
    clk_step();
    check_val("rst_p",    {16'd0, p16}, 32'd0);
    check_val("rst_ovf",  {31'd0, ovf16}, 32'd0);
    check_val("rst_zero", {31'd0, z16}, 32'd1);
    check_val("rst_val7", {24'd0, p99}, 32'd7);

    // Reset raised between edges has no effect until the next edge
    rst = 1'b0;
    do_load(16'd5);
    check_val("load5", {16'd0, p16}, 32'd5);
    rst = 1'b1;
    #3;
    check_val("rst_midcycle", {16'd0, p16}, 32'd5);
    clk_step();
    check_val("rst_at_edge", {16'd0, p16}, 32'd0);
    rst = 1'b0;

`ifdef PCNT_PRESCALE_EN
    // Prescale 4: step every 4th enabled clock
    do_load(16'd0);
    en = 1'b1; up = 1'b1; step = 16'd1;
    clk_step(); clk_step(); clk_step();
    check_val("ps_3clk", {16'd0, p16}, 32'd0);
    clk_step();
    check_val("ps_4clk", {16'd0, p16}, 32'd1);
    clk_step(); clk_step();
    en = 1'b0;
    clk_step(); clk_step(); clk_step();
    check_val("ps_frozen", {16'd0, p16}, 32'd1);
    en = 1'b1;
    clk_step();
    check_val("ps_resume3", {16'd0, p16}, 32'd1);
    clk_step();
    check_val("ps_resume4", {16'd0, p16}, 32'd2);
    clk_step();
    // Load mid-phase restarts the phase
    en = 1'b1; load = 1'b1; lv = 16'd10;
    clk_step();
    load = 1'b0;
    clk_step(); clk_step(); clk_step();
    check_val("ps_load3", {16'd0, p16}, 32'd10);
    clk_step();
    check_val("ps_load4", {16'd0, p16}, 32'd11);
`else
    // 16-bit wrap at full range
    do_load(16'hFFFE);
    check_val("c16_load", {16'd0, p16}, 32'hFFFE);
    en = 1'b1; up = 1'b1; step = 16'd1;
    clk_step();
    check_val("c16_ffff",     {16'd0, p16}, 32'hFFFF);
    check_val("c16_ffff_ovf", {31'd0, ovf16}, 32'd0);
    clk_step();
    check_val("c16_wrap",      {16'd0, p16}, 32'd0);
    check_val("c16_wrap_ovf",  {31'd0, ovf16}, 32'd1);
    check_val("c16_wrap_zero", {31'd0, z16}, 32'd1);
    clk_step();
    check_val("c16_one",     {16'd0, p16}, 32'd1);
    check_val("c16_one_ovf", {31'd0, ovf16}, 32'd0);

    // Mod-10 up by 3 from 8: wrap gives 1, saturate gives 9 repeatedly
    do_load(16'd8);
    en = 1'b1; up = 1'b1; step = 16'd3;
    clk_step();
    check_val("m9_up_wrap",     {28'd0, p9w}, 32'd1);
    check_val("m9_up_wrap_ovf", {31'd0, ovf9w}, 32'd1);
    check_val("s9_up_clip",     {28'd0, p9s}, 32'd9);
    check_val("s9_up_clip_ovf", {31'd0, ovf9s}, 32'd1);
    clk_step();
    check_val("s9_hold2",     {28'd0, p9s}, 32'd9);
    check_val("s9_hold2_ovf", {31'd0, ovf9s}, 32'd1);
    clk_step();
    check_val("s9_hold3",     {28'd0, p9s}, 32'd9);
    check_val("s9_hold3_ovf", {31'd0, ovf9s}, 32'd1);

    // Mod-10 down by 4 from 1 wraps to 7, then 3 without flag
    do_load(16'd1);
    en = 1'b1; up = 1'b0; step = 16'd4;
    clk_step();
    check_val("m9_dn_wrap",     {28'd0, p9w}, 32'd7);
    check_val("m9_dn_wrap_ovf", {31'd0, ovf9w}, 32'd1);
    clk_step();
    check_val("m9_dn3",     {28'd0, p9w}, 32'd3);
    check_val("m9_dn3_ovf", {31'd0, ovf9w}, 32'd0);
    // Step above MAX_VAL is clamped to 9: 3+9=12 -> 2
    up = 1'b1; step = 16'd15;
    clk_step();
    check_val("m9_bigstep",     {28'd0, p9w}, 32'd2);
    check_val("m9_bigstep_ovf", {31'd0, ovf9w}, 32'd1);

    // Saturating down by 5 from 2 clips to 0 and stays there
    do_load(16'd2);
    en = 1'b1; up = 1'b0; step = 16'd5;
    clk_step();
    check_val("s9_dn_clip",      {28'd0, p9s}, 32'd0);
    check_val("s9_dn_clip_ovf",  {31'd0, ovf9s}, 32'd1);
    check_val("s9_dn_clip_zero", {31'd0, z9s}, 32'd1);
    clk_step();
    check_val("s9_dn_hold_ovf", {31'd0, ovf9s}, 32'd1);
    // u_mod9 went 2 -> 7 -> 2; a zero step holds without a flag
    step = 16'd0; up = 1'b1;
    clk_step();
    check_val("m9_step0",     {28'd0, p9w}, 32'd2);
    check_val("m9_step0_ovf", {31'd0, ovf9w}, 32'd0);
    // Enable low holds
    en = 1'b0; step = 16'd1;
    clk_step();
    check_val("m9_en_low", {28'd0, p9w}, 32'd2);

    // Load beats enable and is clamped to MAX_VAL
    en = 1'b1; up = 1'b1; step = 16'd1; load = 1'b1; lv = 16'd200;
    clk_step();
    check_val("c99_load_clamp", {24'd0, p99}, 32'd99);
    check_val("c99_load_ovf",   {31'd0, ovf99}, 32'd0);
    // Reset beats load
    rst = 1'b1; lv = 16'd50;
    clk_step();
    check_val("c99_rst_load", {24'd0, p99}, 32'd7);
    rst = 1'b0;
    // 98 + 3 wraps modulo 100 to 1
    do_load(16'd98);
    en = 1'b1; up = 1'b1; step = 16'd3;
    clk_step();
    check_val("c99_wrap",     {24'd0, p99}, 32'd1);
    check_val("c99_wrap_ovf", {31'd0, ovf99}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
